// File: rtl/controlador_matriz_ram.sv
// Moves one NUM_ELEM-word matrix between a flattened bus and a single-port RAM,
// one access per cycle, with an in-flight tag pipeline covering the RAM read latency.
module controlador_matriz_ram #(
    parameter int NUM_ELEM    = 25,
    parameter int LARGURA     = 9,
    parameter int ADDR_W      = 8,
    parameter int LAT_LEITURA = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        inicia,
    input  logic                        operacao,
    input  logic [ADDR_W-1:0]           endereco_base,
    input  logic [NUM_ELEM*LARGURA-1:0] matriz_in,
    output logic [NUM_ELEM*LARGURA-1:0] matriz_out,
    output logic                        ocupado,
    output logic                        pronto,
    output logic [ADDR_W-1:0]           endereco,
    output logic [LARGURA-1:0]          dado_entrada,
    output logic                        grava,
    input  logic [LARGURA-1:0]          dado_saida
);

    localparam int CNT_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(NUM_ELEM - 1);

    typedef enum logic [2:0] {OCIOSO, LEITURA, DRENO, ESCRITA, FIM} estado_t;

    estado_t                      estado, prox_estado;
    logic [CNT_W-1:0]             cnt, cnt_inc;
    logic [ADDR_W-1:0]            base_q;
    logic [NUM_ELEM*LARGURA-1:0]  matriz_q;
    logic [LAT_LEITURA:1]         vld_pipe;
    logic [LAT_LEITURA:1][CNT_W-1:0] idx_pipe;

    logic aceita, ultimo, captura, captura_ultima, emitindo;

    // FIM doubles as an idle cycle so back-to-back commands lose no cycle.
    assign aceita         = inicia && (estado == OCIOSO || estado == FIM);
    assign ultimo         = (cnt == ULTIMO);
    assign cnt_inc        = cnt + 1'b1;
    assign captura        = vld_pipe[LAT_LEITURA];
    assign captura_ultima = captura && (idx_pipe[LAT_LEITURA] == ULTIMO);
    assign emitindo       = (estado == LEITURA) || (estado == ESCRITA);

    assign ocupado = (estado == LEITURA) || (estado == DRENO) || (estado == ESCRITA);
    assign pronto  = (estado == FIM);

    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO, FIM: begin
                if (aceita) prox_estado = operacao ? ESCRITA : LEITURA;
                else        prox_estado = OCIOSO;
            end
            LEITURA: if (ultimo)         prox_estado = DRENO;
            DRENO:   if (captura_ultima) prox_estado = FIM;
            ESCRITA: if (ultimo)         prox_estado = FIM;
            default:                     prox_estado = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            estado       <= OCIOSO;
            cnt          <= '0;
            base_q       <= '0;
            matriz_q     <= '0;
            vld_pipe     <= '0;
            idx_pipe     <= '0;
            matriz_out   <= '0;
            endereco     <= '0;
            dado_entrada <= '0;
            grava        <= 1'b0;
        end else begin
            estado <= prox_estado;

            // Each read issue is tagged with its element index; the tag
            // reaches the last stage exactly when its word is on dado_saida.
            vld_pipe[1] <= (estado == LEITURA);
            idx_pipe[1] <= cnt;
            for (int k = 2; k <= LAT_LEITURA; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
            if (captura)
                matriz_out[idx_pipe[LAT_LEITURA]*LARGURA +: LARGURA] <= dado_saida;

            grava <= 1'b0;
            if (aceita) begin
                base_q   <= endereco_base;
                matriz_q <= matriz_in;
                cnt      <= '0;
                endereco <= endereco_base;
                grava    <= operacao;
                if (operacao) dado_entrada <= matriz_in[LARGURA-1:0];
            end else if (emitindo && !ultimo) begin
                cnt      <= cnt_inc;
                endereco <= base_q + ADDR_W'(cnt_inc);
                if (estado == ESCRITA) begin
                    grava        <= 1'b1;
                    dado_entrada <= matriz_q[cnt_inc*LARGURA +: LARGURA];
                end
            end
        end
    end

endmodule

// File: tb/tb_controlador_matriz_ram.sv
// Bench for controlador_matriz_ram: behavioural 2-cycle RAM plus queue scoreboard.
module tb_controlador_matriz_ram;

    localparam int N   = 25;
    localparam int W   = 9;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam logic [W-1:0] SENT = 9'h1AA;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              inicia;
    logic              operacao;
    logic [AW-1:0]     endereco_base;
    logic [N*W-1:0]    matriz_in;
    logic [N*W-1:0]    matriz_out;
    logic              ocupado;
    logic              pronto;
    logic [AW-1:0]     endereco;
    logic [W-1:0]      dado_entrada;
    logic              grava;
    logic [W-1:0]      dado_saida;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  q_dado[$];
    logic [AW-1:0] q_addr[$];

    controlador_matriz_ram #(.NUM_ELEM(N), .LARGURA(W), .ADDR_W(AW), .LAT_LEITURA(LAT)) dut (
        .clk(clk), .reset_n(reset_n), .inicia(inicia), .operacao(operacao),
        .endereco_base(endereco_base), .matriz_in(matriz_in), .matriz_out(matriz_out),
        .ocupado(ocupado), .pronto(pronto), .endereco(endereco),
        .dado_entrada(dado_entrada), .grava(grava), .dado_saida(dado_saida)
    );

    always #5 clk = ~clk;

    // RAM: registered address, registered output -> data valid two cycles after endereco.
    logic [W-1:0]  mem [0:255];
    logic [AW-1:0] addr_r;
    always @(posedge clk) begin
        if (grava === 1'b1) mem[endereco] = dado_entrada;
        dado_saida <= mem[addr_r];
        addr_r     <= endereco;
    end

    function automatic logic [N*W-1:0] padrao(input int kind);
        logic [N*W-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       m[i*W +: W] = W'(i*3 + 1);
                1:       m[i*W +: W] = W'(32'h100 | i);
                2:       m[i*W +: W] = W'(i*37 + 5);
                default: m[i*W +: W] = W'(32'h0A0 + i);
            endcase
        end
        return m;
    endfunction

    task automatic start_op(input logic op, input logic [AW-1:0] base, input logic [N*W-1:0] m);
        inicia        = 1'b1;
        operacao      = op;
        endereco_base = base;
        matriz_in     = m;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; inicia = 1'b0; operacao = 1'b0;
        endereco_base = '0; matriz_in = '0;
        for (int a = 0; a < 256; a++) mem[a] = SENT;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (grava !== 1'b0)        begin errors++; $display("FAIL reset_grava got %b want 0", grava); end
        checks++; if (ocupado !== 1'b0)      begin errors++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
        checks++; if (pronto !== 1'b0)       begin errors++; $display("FAIL reset_pronto got %b want 0", pronto); end
        checks++; if (endereco !== '0)       begin errors++; $display("FAIL reset_endereco got %h want 0", endereco); end
        checks++; if (dado_entrada !== '0)   begin errors++; $display("FAIL reset_dado got %h want 0", dado_entrada); end
        checks++; if (matriz_out !== '0)     begin errors++; $display("FAIL reset_matriz_out got %h want 0", matriz_out); end
        reset_n = 1'b1;
    endtask

    // Load: cycle 0 is the negedge where inicia is driven (or already driven by caller).
    task automatic run_load(input string nome, input logic [AW-1:0] base, input logic [N*W-1:0] exp_m,
                            input bit inject_busy, input bit chain, input logic [AW-1:0] chain_base,
                            input bit pre_started);
        bit done;
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        if (!pre_started) begin
            @(negedge clk);
            start_op(1'b0, base, '0);
        end
        for (int i = 0; i < N; i++) begin
            q_dado.push_back(exp_m[i*W +: W]);
            q_addr.push_back(AW'(base + i));
        end
        done = 0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            inicia   = inject_busy && (cyc == 5);
            operacao = inicia;
            if (inicia) begin endereco_base = 8'h80; matriz_in = padrao(3); end
            checks++; if (grava !== 1'b0) begin errors++; $display("FAIL %s grava cyc %0d got %b want 0", nome, cyc, grava); end
            if (cyc <= N) begin
                ea = q_addr.pop_front();
                checks++; if (endereco !== ea) begin errors++; $display("FAIL %s endereco cyc %0d got %h want %h", nome, cyc, endereco, ea); end
                checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL %s ocupado cyc %0d got %b want 1", nome, cyc, ocupado); end
            end
            checks++;
            if (pronto !== (cyc == N + LAT + 1)) begin errors++; $display("FAIL %s pronto cyc %0d got %b want %b", nome, cyc, pronto, cyc == N + LAT + 1); end
            if (pronto === 1'b1) begin
                done = 1;
                checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL %s ocupado_pronto got %b want 0", nome, ocupado); end
                for (int i = 0; i < N; i++) begin
                    ed = q_dado.pop_front();
                    checks++;
                    if (matriz_out[i*W +: W] !== ed) begin errors++; $display("FAIL %s slot %0d got %h want %h", nome, i, matriz_out[i*W +: W], ed); end
                end
                if (chain) start_op(1'b0, chain_base, '0);
            end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL %s timeout pronto got 0 want 1", nome);
            inicia = 1'b0;
        end
        q_dado.delete();
        q_addr.delete();
    endtask

    // Store; rst_cyc != 0 drops reset_n in that cycle and checks the aftermath.
    task automatic run_store(input string nome, input logic [AW-1:0] base, input logic [N*W-1:0] m, input int rst_cyc);
        bit done;
        logic [AW-1:0] ea;
        logic [W-1:0]  ed, want;
        @(negedge clk);
        start_op(1'b1, base, m);
        for (int i = 0; i < N; i++) begin
            q_addr.push_back(AW'(base + i));
            q_dado.push_back(m[i*W +: W]);
        end
        done = 0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(negedge clk);
            inicia = 1'b0;
            matriz_in = ~m;
            endereco_base = ~base;
            if (rst_cyc != 0 && cyc == rst_cyc + 1) begin
                checks++; if (grava !== 1'b0)    begin errors++; $display("FAIL %s rst_grava got %b want 0", nome, grava); end
                checks++; if (ocupado !== 1'b0)  begin errors++; $display("FAIL %s rst_ocupado got %b want 0", nome, ocupado); end
                checks++; if (pronto !== 1'b0)   begin errors++; $display("FAIL %s rst_pronto got %b want 0", nome, pronto); end
                checks++; if (matriz_out !== '0) begin errors++; $display("FAIL %s rst_matriz_out got %h want 0", nome, matriz_out); end
                reset_n = 1'b1;
                done = 1;
            end else begin
                checks++;
                if (grava !== (cyc <= N)) begin errors++; $display("FAIL %s grava cyc %0d got %b want %b", nome, cyc, grava, cyc <= N); end
                if (grava === 1'b1 && q_addr.size() > 0) begin
                    ea = q_addr.pop_front();
                    ed = q_dado.pop_front();
                    checks++; if (endereco !== ea)     begin errors++; $display("FAIL %s endereco cyc %0d got %h want %h", nome, cyc, endereco, ea); end
                    checks++; if (dado_entrada !== ed) begin errors++; $display("FAIL %s dado cyc %0d got %h want %h", nome, cyc, dado_entrada, ed); end
                end
                checks++;
                if (pronto !== (cyc == N + 1)) begin errors++; $display("FAIL %s pronto cyc %0d got %b want %b", nome, cyc, pronto, cyc == N + 1); end
                if (pronto === 1'b1) done = 1;
                if (rst_cyc != 0 && cyc == rst_cyc) reset_n = 1'b0;
            end
        end
        if (!done) begin
            errors++; checks++;
            $display("FAIL %s timeout pronto got 0 want 1", nome);
        end
        q_addr.delete();
        q_dado.delete();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            want = (rst_cyc == 0 || i < rst_cyc) ? m[i*W +: W] : SENT;
            checks++;
            if (mem[AW'(base + i)] !== want) begin errors++; $display("FAIL %s ram %h got %h want %h", nome, AW'(base + i), mem[AW'(base + i)], want); end
        end
    endtask

    task automatic test_load();
        for (int i = 0; i < N; i++) mem[8'h10 + i] = W'(i*3 + 1);
        run_load("load", 8'h10, padrao(0), 0, 0, '0, 0);
    endtask

    task automatic test_store();
        run_store("store", 8'h40, padrao(1), 0);
        run_load("load_back", 8'h40, padrao(1), 0, 0, '0, 0);
    endtask

    task automatic test_wrap();
        run_store("wrap_store", 8'hF0, padrao(2), 0);
        run_load("wrap_load", 8'hF0, padrao(2), 0, 0, '0, 0);
    endtask

    task automatic test_back_to_back();
        run_load("busy_load", 8'h10, padrao(0), 1, 1, 8'h40, 0);
        run_load("chained_load", 8'h40, padrao(1), 0, 0, '0, 1);
    endtask

    task automatic test_reset_mid_store();
        logic [N*W-1:0] esperado;
        run_store("rst_store", 8'h60, padrao(3), 9);
        esperado = padrao(3);
        for (int i = 9; i < N; i++) esperado[i*W +: W] = SENT;
        run_load("post_rst_load", 8'h60, esperado, 0, 0, '0, 0);
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_wrap();
        test_back_to_back();
        test_reset_mid_store();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
